// File: rtl/vr_broadcast_sched.sv
// vr_broadcast_sched: sequences one VR broadcast (StartViewChange, DoViewChange, ...)
// by issuing one send request per peer replica and skipping the local index.
// The number of issued-but-uncompleted sends is bounded. Completions are counted,
// and the requesting engine controller sees "done" when broadcast_rdy returns high.

package beehive_vr_pkg;
    typedef logic [3:0] msg_type;
endpackage

module vr_broadcast_sched
    import beehive_vr_pkg::*;
#(
    parameter int MAX_REPLICAS  = 8,
    parameter int REPLICA_IDX_W = 3,
    parameter int MAX_INFLIGHT  = 2,
    parameter int VIEW_W        = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_broadcast,
    output logic                     broadcast_rdy,
    input  logic [REPLICA_IDX_W:0]   cfg_num_replicas,
    input  logic [REPLICA_IDX_W-1:0] cfg_my_idx,
    input  logic [VIEW_W-1:0]        start_view,
    input  msg_type                  start_msg_type,
    output logic                     send_req_val,
    input  logic                     send_req_rdy,
    output logic [REPLICA_IDX_W-1:0] send_req_dst_idx,
    output logic [VIEW_W-1:0]        send_req_view,
    output msg_type                  send_req_msg_type,
    input  logic                     send_done_val,
    output logic [REPLICA_IDX_W:0]   bcast_sent_cnt,
    output logic                     bcast_err
);

    localparam int CNT_W = REPLICA_IDX_W + 1;
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] NUM_MAX = CNT_W'(MAX_REPLICAS);
    localparam logic [INF_W-1:0] INF_MAX = INF_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Registered state. The destination index is one bit wider than a replica
    // index so that "past the last replica" (== num) can be represented.
    state_e                   state_r;
    logic [CNT_W-1:0]         dst_r;
    logic [CNT_W-1:0]         num_r;
    logic [REPLICA_IDX_W-1:0] my_idx_r;
    logic [VIEW_W-1:0]        view_r;
    msg_type                  type_r;
    logic [INF_W-1:0]         inflight_r;
    logic [CNT_W-1:0]         sent_cnt_r;
    logic                     err_r;
    logic                     val_r;
    logic                     rdy_r;

    // Next-state values.
    state_e                   state_n_s;
    logic [CNT_W-1:0]         dst_n_s;
    logic [CNT_W-1:0]         num_n_s;
    logic [REPLICA_IDX_W-1:0] my_idx_n_s;
    logic [VIEW_W-1:0]        view_n_s;
    msg_type                  type_n_s;
    logic [INF_W-1:0]         inflight_n_s;
    logic [CNT_W-1:0]         sent_cnt_n_s;
    logic [CNT_W-1:0]         first_dst_s;
    logic [CNT_W-1:0]         start_num_s;
    logic                     accept_s;
    logic                     done_ok_s;
    logic                     stray_s;

    // Cluster size is clamped to what the scheduler can address.
    function automatic logic [CNT_W-1:0] clamp_num(input logic [CNT_W-1:0] n);
        if (n > NUM_MAX) begin
            return NUM_MAX;
        end else begin
            return n;
        end
    endfunction

    // Advance to the next destination, skipping the local replica.
    function automatic logic [CNT_W-1:0] step_dst(input logic [CNT_W-1:0] cur,
                                                  input logic [REPLICA_IDX_W-1:0] me);
        logic [CNT_W-1:0] nxt;
        nxt = cur + CNT_W'(1);
        if (nxt == {1'b0, me}) begin
            return cur + CNT_W'(2);
        end else begin
            return nxt;
        end
    endfunction

    // Handshake decode: a completion is only valid while something is in flight.
    always_comb begin
        accept_s    = val_r & send_req_rdy;
        done_ok_s   = send_done_val & (inflight_r != INF_W'(0));
        stray_s     = send_done_val & (inflight_r == INF_W'(0));
        first_dst_s = (cfg_my_idx == REPLICA_IDX_W'(0)) ? CNT_W'(1) : CNT_W'(0);
        start_num_s = clamp_num(cfg_num_replicas);
    end

    // In-flight accounting: accept and completion in one cycle cancel out.
    always_comb begin
        inflight_n_s = inflight_r;
        case ({accept_s, done_ok_s})
            2'b10:   inflight_n_s = inflight_r + INF_W'(1);
            2'b01:   inflight_n_s = inflight_r - INF_W'(1);
            default: inflight_n_s = inflight_r;
        endcase
    end

    // Broadcast sequencing: latch at start, walk destinations, drain, finish.
    always_comb begin
        state_n_s    = state_r;
        dst_n_s      = dst_r;
        num_n_s      = num_r;
        my_idx_n_s   = my_idx_r;
        view_n_s     = view_r;
        type_n_s     = type_r;
        sent_cnt_n_s = sent_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_broadcast) begin
                    num_n_s      = start_num_s;
                    my_idx_n_s   = cfg_my_idx;
                    view_n_s     = start_view;
                    type_n_s     = start_msg_type;
                    sent_cnt_n_s = CNT_W'(0);
                    dst_n_s      = first_dst_s;
                    if (first_dst_s >= start_num_s) begin
                        state_n_s = ST_FINISH;
                    end else begin
                        state_n_s = ST_ISSUE;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s) begin
                    dst_n_s      = step_dst(dst_r, my_idx_r);
                    sent_cnt_n_s = sent_cnt_r + CNT_W'(1);
                    if (step_dst(dst_r, my_idx_r) >= num_r) begin
                        state_n_s = ST_DRAIN;
                    end else begin
                        state_n_s = ST_ISSUE;
                    end
                end else begin
                    state_n_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (inflight_n_s == INF_W'(0)) begin
                    state_n_s = ST_FINISH;
                end else begin
                    state_n_s = ST_DRAIN;
                end
            end
            ST_FINISH: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; valid/ready derive from next state only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            dst_r      <= CNT_W'(0);
            num_r      <= CNT_W'(0);
            my_idx_r   <= REPLICA_IDX_W'(0);
            view_r     <= VIEW_W'(0);
            type_r     <= msg_type'(4'd0);
            inflight_r <= INF_W'(0);
            sent_cnt_r <= CNT_W'(0);
            err_r      <= 1'b0;
            val_r      <= 1'b0;
            rdy_r      <= 1'b1;
        end else begin
            state_r    <= state_n_s;
            dst_r      <= dst_n_s;
            num_r      <= num_n_s;
            my_idx_r   <= my_idx_n_s;
            view_r     <= view_n_s;
            type_r     <= type_n_s;
            inflight_r <= inflight_n_s;
            sent_cnt_r <= sent_cnt_n_s;
            err_r      <= err_r | stray_s;
            val_r      <= (state_n_s == ST_ISSUE) && (inflight_n_s < INF_MAX);
            rdy_r      <= (state_n_s == ST_IDLE);
        end
    end

    assign broadcast_rdy     = rdy_r;
    assign send_req_val      = val_r;
    assign send_req_dst_idx  = dst_r[REPLICA_IDX_W-1:0];
    assign send_req_view     = view_r;
    assign send_req_msg_type = type_r;
    assign bcast_sent_cnt    = sent_cnt_r;
    assign bcast_err         = err_r;

endmodule

// File: tb/tb_vr_broadcast_sched.sv
// Self-checking bench for vr_broadcast_sched: table of broadcast scenarios with
// random handshakes checked against a destination-list reference model, plus
// hand-written sequences for backpressure, empty broadcast, stray completion and reset.

module tb_vr_broadcast_sched;
    import beehive_vr_pkg::*;

    localparam int MAXR = 8;
    localparam int IW   = 3;
    localparam int MAXI = 2;
    localparam int VW   = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_broadcast;
    logic          broadcast_rdy;
    logic [IW:0]   cfg_num_replicas;
    logic [IW-1:0] cfg_my_idx;
    logic [VW-1:0] start_view;
    msg_type       start_msg_type;
    logic          send_req_val;
    logic          send_req_rdy;
    logic [IW-1:0] send_req_dst_idx;
    logic [VW-1:0] send_req_view;
    msg_type       send_req_msg_type;
    logic          send_done_val;
    logic [IW:0]   bcast_sent_cnt;
    logic          bcast_err;

    always #5 clk = ~clk;

    vr_broadcast_sched #(
        .MAX_REPLICAS(MAXR), .REPLICA_IDX_W(IW), .MAX_INFLIGHT(MAXI), .VIEW_W(VW)
    ) dut (
        .clk(clk), .rst(rst),
        .start_broadcast(start_broadcast), .broadcast_rdy(broadcast_rdy),
        .cfg_num_replicas(cfg_num_replicas), .cfg_my_idx(cfg_my_idx),
        .start_view(start_view), .start_msg_type(start_msg_type),
        .send_req_val(send_req_val), .send_req_rdy(send_req_rdy),
        .send_req_dst_idx(send_req_dst_idx), .send_req_view(send_req_view),
        .send_req_msg_type(send_req_msg_type), .send_done_val(send_done_val),
        .bcast_sent_cnt(bcast_sent_cnt), .bcast_err(bcast_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a broadcast is the list of peers still to be sent,
    // an outstanding-send count, and a coarse phase (0 idle, 1 busy, 2 finishing).
    int       m_phase;
    int       m_q[$];
    int       m_out;
    int       m_sent;
    bit       m_err;
    logic [VW-1:0] m_view;
    msg_type  m_type;

    function automatic bit m_val();
        return (m_phase == 1) && (m_q.size() > 0) && (m_out < MAXI);
    endfunction

    task automatic model_step();
        bit acc;
        bit dok;
        bit draining;
        int n;
        if (rst) begin
            m_phase = 0; m_q.delete(); m_out = 0; m_sent = 0; m_err = 1'b0;
            m_view = '0; m_type = msg_type'(4'd0);
        end else begin
            acc      = m_val() && send_req_rdy;
            dok      = send_done_val && (m_out > 0);
            if (send_done_val && m_out == 0) m_err = 1'b1;
            draining = (m_q.size() == 0);
            if (acc) begin
                void'(m_q.pop_front());
                m_sent++;
            end
            m_out = m_out + int'(acc) - int'(dok);
            case (m_phase)
                0: if (start_broadcast) begin
                    n = (int'(cfg_num_replicas) > MAXR) ? MAXR : int'(cfg_num_replicas);
                    m_q.delete();
                    for (int i = 0; i < n; i++)
                        if (i != int'(cfg_my_idx)) m_q.push_back(i);
                    m_view  = start_view;
                    m_type  = start_msg_type;
                    m_sent  = 0;
                    m_phase = (m_q.size() == 0) ? 2 : 1;
                end
                1: if (draining && m_out == 0) m_phase = 2;
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("broadcast_rdy", broadcast_rdy, 64'(m_phase == 0));
        chk("send_req_val", send_req_val, 64'(m_val()));
        chk("bcast_sent_cnt", bcast_sent_cnt, 64'(m_sent));
        chk("bcast_err", bcast_err, 64'(m_err));
        if (m_val()) begin
            chk("dst_idx", send_req_dst_idx, 64'(m_q[0]));
            chk("view", send_req_view, m_view);
            chk("msg_type", send_req_msg_type, 64'(m_type));
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic start_pulse(input int num, input int my);
        cfg_num_replicas = (IW+1)'(num);
        cfg_my_idx       = IW'(my);
        start_view       = {$urandom, $urandom};
        start_msg_type   = msg_type'(4'($urandom_range(0, 15)));
        start_broadcast  = 1'b1;
        cycle();
        start_broadcast  = 1'b0;
    endtask

    task automatic run_bcast(input int num, input int my, input int rdy_pct,
                             input int done_pct, input int exp_sent);
        int guard;
        send_done_val = 1'b0;
        send_req_rdy  = ($urandom_range(0, 99) < rdy_pct);
        start_pulse(num, my);
        guard = 0;
        while (m_phase != 0 && guard < 500) begin
            send_req_rdy    = ($urandom_range(0, 99) < rdy_pct);
            send_done_val   = (m_out > 0) && ($urandom_range(0, 99) < done_pct);
            start_broadcast = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cfg_num_replicas = (IW+1)'($urandom_range(0, 15));
                cfg_my_idx       = IW'($urandom_range(0, 7));
                start_view       = {$urandom, $urandom};
                start_msg_type   = msg_type'(4'($urandom_range(0, 15)));
            end
            cycle();
            guard++;
        end
        start_broadcast = 1'b0;
        send_done_val   = 1'b0;
        chk("bcast_timeout", 64'(m_phase), 64'd0);
        chk("table_sent_cnt", bcast_sent_cnt, 64'(exp_sent));
    endtask

    typedef struct {
        int num;
        int my;
        int rdy_pct;
        int done_pct;
        int exp_sent;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int busy;
        int seen_val;
        int guard;

        tbl[0] = '{3,  0, 100, 60, 2};
        tbl[1] = '{5,  2,  70, 50, 4};
        tbl[2] = '{1,  0, 100, 50, 0};
        tbl[3] = '{4,  1,  50, 50, 3};
        tbl[4] = '{15, 7,  80, 40, 7};
        tbl[5] = '{0,  0, 100, 50, 0};
        tbl[6] = '{3,  5,  60, 70, 3};
        tbl[7] = '{8,  0,  90, 30, 7};
        tbl[8] = '{8,  7,  40, 90, 7};
        tbl[9] = '{2,  1,  30, 20, 1};

        rst = 1'b1; start_broadcast = 1'b0; send_req_rdy = 1'b0; send_done_val = 1'b0;
        cfg_num_replicas = '0; cfg_my_idx = '0; start_view = '0; start_msg_type = msg_type'(4'd0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("reset_rdy", broadcast_rdy, 64'd1);
        chk("reset_val", send_req_val, 64'd0);
        chk("reset_sent", bcast_sent_cnt, 64'd0);

        for (int i = 0; i < 10; i++)
            run_bcast(tbl[i].num, tbl[i].my, tbl[i].rdy_pct, tbl[i].done_pct, tbl[i].exp_sent);

        // Backpressure from the in-flight bound: completions withheld.
        send_req_rdy = 1'b1;
        start_pulse(5, 2);
        for (int i = 0; i < 5; i++) cycle();
        chk("bound_sent", bcast_sent_cnt, 64'd2);
        chk("bound_val", send_req_val, 64'd0);
        send_done_val = 1'b1;
        cycle();
        send_done_val = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("one_done_sent", bcast_sent_cnt, 64'd3);
        guard = 0;
        while (m_phase != 0 && guard < 50) begin
            send_done_val = (m_out > 0);
            cycle();
            guard++;
        end
        send_done_val = 1'b0;
        chk("bound_timeout", 64'(m_phase), 64'd0);
        chk("bound_final_sent", bcast_sent_cnt, 64'd4);

        // No peers: busy for exactly one cycle and no requests.
        busy = 0; seen_val = 0;
        start_pulse(1, 0);
        busy += int'(!broadcast_rdy); seen_val += int'(send_req_val);
        for (int i = 0; i < 4; i++) begin
            cycle();
            busy += int'(!broadcast_rdy); seen_val += int'(send_req_val);
        end
        chk("min_busy_cycles", 64'(busy), 64'd1);
        chk("no_peer_val", 64'(seen_val), 64'd0);

        // Stray completion while idle sets a sticky error.
        send_done_val = 1'b1;
        cycle();
        send_done_val = 1'b0;
        chk("stray_err", bcast_err, 64'd1);
        for (int i = 0; i < 3; i++) cycle();
        chk("err_sticky", bcast_err, 64'd1);

        // Reset in the middle of issuing.
        send_req_rdy = 1'b0;
        start_pulse(8, 0);
        cycle();
        send_req_rdy = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_val", send_req_val, 64'd0);
        chk("rst_rdy", broadcast_rdy, 64'd1);
        chk("rst_err", bcast_err, 64'd0);
        send_done_val = 1'b1;
        cycle();
        send_done_val = 1'b0;
        chk("post_rst_done_err", bcast_err, 64'd1);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
